// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkgen_pkg
// Description : Shared definitions for the DCM_CLKGEN reprogramming
//               controller: FSM state encoding, serial command prefixes,
//               frame length, default M/D codes and the M-code clamp.
// Revision    : 1.0 - initial release
// ============================================================================
package clkgen_pkg;

   // Controller states, explicitly 3 bits wide
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_D    = 3'd1,
      ST_GAP_D     = 3'd2,
      ST_LOAD_M    = 3'd3,
      ST_GAP_M     = 3'd4,
      ST_GO        = 3'd5,
      ST_WAIT_DONE = 3'd6
   } state_t;

   // Two-bit command prefixes, bit0 goes out on PROGDATA first
   localparam logic [1:0]  CMD_LOAD_D    = 2'b01;
   localparam logic [1:0]  CMD_LOAD_M    = 2'b11;

   // Prefix (2) + value (8) bits per command frame
   localparam int unsigned FRAME_LEN     = 10;

   // M-1 / D-1 codes the controller reports out of reset (M = D = 2)
   localparam logic [7:0]  DEF_MULT_CODE = 8'd1;
   localparam logic [7:0]  DEF_DIV_CODE  = 8'd1;

   // Width of the PROGDONE watchdog counter
   localparam int unsigned TIMER_W       = 13;

   // M = 1 is not a legal DCM_CLKGEN setting, so an M-1 code of 0 becomes 1
   function automatic logic [7:0] clamp_mult(input logic [7:0] code);
      return (code == 8'd0) ? 8'd1 : code;
   endfunction

endpackage : clkgen_pkg
`default_nettype wire

// File: rtl/clkgen_serializer.sv
`default_nettype none
// ============================================================================
// Module      : clkgen_serializer
// Description : Shifts one 10-bit DCM_CLKGEN command frame (2-bit prefix then
//               8-bit value, LSB first) onto PROGEN/PROGDATA, one bit per
//               clock starting the cycle after i_start. i_go produces the
//               single-cycle GO command (PROGEN=1, PROGDATA=0). Both pins
//               are driven straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module clkgen_serializer
   import clkgen_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic       i_go,
   input  logic [1:0] i_prefix,
   input  logic [7:0] i_value,
   output logic       o_progen,
   output logic       o_progdata,
   output logic       o_last
);

   localparam int unsigned CNT_W = $clog2(FRAME_LEN);

   logic [FRAME_LEN-1:0] r_shift;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_active;
   logic                 r_progen;
   logic                 r_progdata;
   logic                 w_final_bit;

   assign w_final_bit = (r_cnt == CNT_W'(FRAME_LEN - 1));

   // Load a frame on start, then emit one bit per cycle until the frame is out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift    <= '0;
         r_cnt      <= '0;
         r_active   <= 1'b0;
         r_progen   <= 1'b0;
         r_progdata <= 1'b0;
      end else if (r_active) begin
         r_progen   <= 1'b1;
         r_progdata <= r_shift[0];
         r_shift    <= {1'b0, r_shift[FRAME_LEN-1:1]};
         if (w_final_bit) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
         end else begin
            r_cnt    <= r_cnt + 1'b1;
         end
      end else begin
         r_progen   <= i_go;
         r_progdata <= 1'b0;
         if (i_start) begin
            r_shift  <= {i_value, i_prefix};
            r_cnt    <= '0;
            r_active <= 1'b1;
         end
      end
   end

   assign o_progen   = r_progen;
   assign o_progdata = r_progdata;
   // High in the cycle whose clock edge drives the final frame bit
   assign o_last     = r_active && w_final_bit;

endmodule : clkgen_serializer
`default_nettype wire

// File: rtl/dcm_clkgen_program.sv
`default_nettype none
// ============================================================================
// Module      : dcm_clkgen_program
// Description : Serial reprogramming controller for DCM_CLKGEN. On load_i it
//               sends LOAD_D and LOAD_M frames, then GO, on the PROGCLK
//               domain (clk_i), waits for PROGDONE and reports the committed
//               M-1/D-1 codes. All outputs are registered.
//               Optional PROGDONE watchdog: define CLKGEN_PROG_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dcm_clkgen_program
   import clkgen_pkg::*;
#(
   parameter logic [7:0]  DEFAULT_MULT   = DEF_MULT_CODE,
   parameter logic [7:0]  DEFAULT_DIV    = DEF_DIV_CODE,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] mult_i,
   input  logic [7:0] div_i,
   input  logic       load_i,
   output logic [7:0] mult_o,
   output logic [7:0] div_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic       progen_o,
   output logic       progdata_o,
   input  logic       progdone_i
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   // Reject parameter values the counters cannot represent
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("GAP_CYCLES must be at least 1");
   end
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > (1 << TIMER_W))) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range for the watchdog counter");
   end

   state_t           r_state,       w_state_nx;
   logic [GAP_W-1:0] r_gap_cnt,     w_gap_cnt_nx;
   logic [7:0]       r_shadow_mult, w_shadow_mult_nx;
   logic [7:0]       r_shadow_div,  w_shadow_div_nx;
   logic [7:0]       r_mult,        w_mult_nx;
   logic [7:0]       r_div,         w_div_nx;
   logic             r_busy,        w_busy_nx;
   logic             r_done,        w_done_nx;
   logic             r_error,       w_error_nx;
`ifdef CLKGEN_PROG_TIMEOUT_EN
   logic [TIMER_W-1:0] r_timer,     w_timer_nx;
`endif

   logic             w_ser_start;
   logic             w_ser_go;
   logic [1:0]       w_ser_prefix;
   logic [7:0]       w_ser_value;
   logic             w_ser_last;
   logic             w_gap_end;

   assign w_gap_end = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

   // Frame shifter shared by the LOAD_D and LOAD_M commands and the GO pulse
   clkgen_serializer u_serializer (
      .clk        (clk_i),
      .rst        (reset_i),
      .i_start    (w_ser_start),
      .i_go       (w_ser_go),
      .i_prefix   (w_ser_prefix),
      .i_value    (w_ser_value),
      .o_progen   (progen_o),
      .o_progdata (progdata_o),
      .o_last     (w_ser_last)
   );

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state       <= ST_IDLE;
         r_gap_cnt     <= '0;
         r_shadow_mult <= DEFAULT_MULT;
         r_shadow_div  <= DEFAULT_DIV;
         r_mult        <= DEFAULT_MULT;
         r_div         <= DEFAULT_DIV;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
`ifdef CLKGEN_PROG_TIMEOUT_EN
         r_timer       <= '0;
`endif
      end else begin
         r_state       <= w_state_nx;
         r_gap_cnt     <= w_gap_cnt_nx;
         r_shadow_mult <= w_shadow_mult_nx;
         r_shadow_div  <= w_shadow_div_nx;
         r_mult        <= w_mult_nx;
         r_div         <= w_div_nx;
         r_busy        <= w_busy_nx;
         r_done        <= w_done_nx;
         r_error       <= w_error_nx;
`ifdef CLKGEN_PROG_TIMEOUT_EN
         r_timer       <= w_timer_nx;
`endif
      end
   end

   // Next-state logic; the serializer is kicked one state ahead so each
   // frame bit lands on the edge after the state that requested it
   always_comb begin
      w_state_nx       = r_state;
      w_gap_cnt_nx     = r_gap_cnt;
      w_shadow_mult_nx = r_shadow_mult;
      w_shadow_div_nx  = r_shadow_div;
      w_mult_nx        = r_mult;
      w_div_nx         = r_div;
      w_busy_nx        = r_busy;
      w_done_nx        = 1'b0;
      w_error_nx       = r_error;
`ifdef CLKGEN_PROG_TIMEOUT_EN
      w_timer_nx       = r_timer;
`endif
      w_ser_start      = 1'b0;
      w_ser_go         = 1'b0;
      w_ser_prefix     = CMD_LOAD_D;
      w_ser_value      = r_shadow_div;

      case (r_state)
         ST_IDLE: begin
            if (load_i) begin
               w_shadow_mult_nx = clamp_mult(mult_i);
               w_shadow_div_nx  = div_i;
               w_error_nx       = 1'b0;
               w_busy_nx        = 1'b1;
               w_gap_cnt_nx     = '0;
               w_ser_start      = 1'b1;
               w_ser_prefix     = CMD_LOAD_D;
               w_ser_value      = div_i;
               w_state_nx       = ST_LOAD_D;
            end
         end
         ST_LOAD_D: begin
            if (w_ser_last) begin
               w_gap_cnt_nx = '0;
               w_state_nx   = ST_GAP_D;
            end
         end
         ST_GAP_D: begin
            if (w_gap_end) begin
               w_gap_cnt_nx = '0;
               w_ser_start  = 1'b1;
               w_ser_prefix = CMD_LOAD_M;
               w_ser_value  = r_shadow_mult;
               w_state_nx   = ST_LOAD_M;
            end else begin
               w_gap_cnt_nx = r_gap_cnt + 1'b1;
            end
         end
         ST_LOAD_M: begin
            if (w_ser_last) begin
               w_gap_cnt_nx = '0;
               w_state_nx   = ST_GAP_M;
            end
         end
         ST_GAP_M: begin
            if (w_gap_end) begin
               w_gap_cnt_nx = '0;
               w_state_nx   = ST_GO;
            end else begin
               w_gap_cnt_nx = r_gap_cnt + 1'b1;
            end
         end
         ST_GO: begin
            w_ser_go   = 1'b1;
`ifdef CLKGEN_PROG_TIMEOUT_EN
            w_timer_nx = '0;
`endif
            w_state_nx = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (progdone_i) begin
               w_mult_nx  = r_shadow_mult;
               w_div_nx   = r_shadow_div;
               w_done_nx  = 1'b1;
               w_busy_nx  = 1'b0;
               w_state_nx = ST_IDLE;
`ifdef CLKGEN_PROG_TIMEOUT_EN
            end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
               w_error_nx = 1'b1;
               w_busy_nx  = 1'b0;
               w_state_nx = ST_IDLE;
            end else begin
               w_timer_nx = r_timer + 1'b1;
`endif
            end
         end
         default: begin
            w_busy_nx  = 1'b0;
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   assign mult_o  = r_mult;
   assign div_o   = r_div;
   assign busy_o  = r_busy;
   assign done_o  = r_done;
`ifdef CLKGEN_PROG_TIMEOUT_EN
   assign error_o = r_error;
`else
   // Without the watchdog there is no error source
   assign error_o = 1'b0;
`endif

endmodule : dcm_clkgen_program
`default_nettype wire

// File: doc/dcm_clkgen_program.md
Name: dcm_clkgen_program

Overview:
- Serial reprogramming controller for the DCM_CLKGEN that generates the target clock. Drives PROGEN/PROGDATA on the DCM's PROGCLK domain to load new D and M values, then issues GO.
- Waits for PROGDONE and reports the committed M/D values to the register interface, in the same style as the phase-shift interface that sits beside it.
- clk_i drives DCM_CLKGEN PROGCLK directly; all DCM handshake signals are in this domain.

Parameters:
- DEFAULT_MULT, 8'd1, M-1 code reported after reset (M=2)
- DEFAULT_DIV, 8'd1, D-1 code reported after reset (D=2)
- GAP_CYCLES, 2, idle cycles with PROGEN low between commands (min 1)
- TIMEOUT_CYCLES, 4096, PROGDONE watchdog limit (only with optional feature)

Ports:
- clk_i  in  1  clock; also routed to DCM_CLKGEN PROGCLK
- reset_i  in  1  synchronous, active-high reset
- mult_i  in  8  requested M-1 (M = 2..256; code 0 illegal)
- div_i  in  8  requested D-1 (D = 1..256)
- load_i  in  1  start request; sampled only in IDLE
- mult_o  out  8  last committed M-1
- div_o  out  8  last committed D-1
- busy_o  out  1  high from cycle after accepted load until done/error
- done_o  out  1  one-cycle pulse on successful commit
- error_o  out  1  sticky timeout flag; cleared by next accepted load_i
- progen_o  out  1  to DCM_CLKGEN PROGEN
- progdata_o  out  1  to DCM_CLKGEN PROGDATA
- progdone_i  in  1  from DCM_CLKGEN PROGDONE

Behaviour:
- All outputs registered.
- Reset values: progen_o=0, progdata_o=0, busy_o=0, done_o=0, error_o=0, mult_o=DEFAULT_MULT, div_o=DEFAULT_DIV, state=IDLE, counters 0.
- States: IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE.
- IDLE:
  - load_i=1 latches mult_i/div_i into shadow registers and clears error_o.
  - Goes to LOAD_D; busy_o=1 from the next cycle.
  - A mult_i code of 0 is clamped to 1 (M=2) at latch time.
- LOAD_D: 10 cycles, progen_o=1. progdata_o = 1, 0, then D-1 bits[0..7], LSB first. Then GAP_D.
- GAP_D: GAP_CYCLES cycles, progen_o=0, progdata_o=0. Then LOAD_M.
- LOAD_M: 10 cycles, progen_o=1. progdata_o = 1, 1, then M-1 bits[0..7], LSB first. Then GAP_M.
- GAP_M: as GAP_D. Then GO.
- GO: 1 cycle, progen_o=1, progdata_o=0. Then WAIT_DONE.
- WAIT_DONE: progen_o=0. When progdone_i=1:
  - mult_o/div_o take the shadow values;
  - done_o pulses;
  - busy_o falls in the same cycle;
  - return to IDLE.
- Timing with GAP_CYCLES=2 and load_i at cycle 0:
  - first progen_o high at cycle 1;
  - GO at cycle 25;
  - earliest done_o at cycle 26 if progdone_i is already high.
  - progdone_i stays low during the command phases and is ignored outside WAIT_DONE.
- load_i while busy_o=1 or in the accept cycle: ignored; no queuing.
- load_i in the same cycle as done_o: ignored. The first acceptable load is the following cycle.
- reset_i mid-sequence: progen_o drops to 0 on the next edge and the sequence is aborted. The DCM keeps its previous M/D because GO was never issued. Outputs return to reset values.
- mult_o/div_o never change except on successful commit or reset.

Optional Feature:
- Macro: CLKGEN_PROG_TIMEOUT_EN
- With the macro: a 13-bit counter runs in WAIT_DONE.
  - At TIMEOUT_CYCLES without progdone_i: error_o=1 (sticky), busy_o=0, return to IDLE, mult_o/div_o unchanged, no done_o.
- Without the macro: WAIT_DONE waits indefinitely; error_o is tied 0. TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package clkgen_pkg:
  - state encoding constants;
  - command prefixes CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11 (bit0 sent first);
  - frame length 10;
  - default M/D codes.
- One natural sub-module: clkgen_serializer.
  - 10-bit shift register plus bit counter.
  - start/prefix/value inputs; progen/progdata/last outputs.
  - Reused for both LOAD_D and LOAD_M.

Test Plan:
- Reset, then load mult_i=8'd4, div_i=8'd1:
  - progen_o high cycles 1-10 with data 1,0,1,0,0,0,0,0,0,0;
  - cycles 13-22 with data 1,1,0,0,1,0,0,0,0,0;
  - GO at 25;
  - progdone_i at 30 -> done_o at 30, mult_o=4, div_o=1.
- mult_i=0, div_i=8'hFF -> M frame carries 00000001 (clamped), D frame carries 11111111; mult_o=1 after commit.
- load_i pulsed at cycles 5 and 26 during a sequence -> ignored; exactly one done_o; shadow values unchanged.
- reset_i asserted at cycle 15 -> progen_o=0 at 16, busy_o=0, mult_o/div_o = defaults, no GO issued.
- With CLKGEN_PROG_TIMEOUT_EN, TIMEOUT_CYCLES=64, progdone_i held 0 -> error_o=1 at 64 cycles after GO, busy_o=0, mult_o/div_o unchanged; the next load clears error_o.
- Back-to-back: load accepted the cycle after done_o -> second sequence has identical timing; both commits are reflected in order.
